// File: rtl/aes_uart_tx_sched_if.sv
// Handshake bundle between the TX scheduler, its two byte/block sources and the UART transmitter.
interface aes_uart_tx_sched_if;
  logic [7:0]   plain_tdata;
  logic         plain_tvalid;
  logic         plain_tready;
  logic [127:0] enc_tdata;
  logic         enc_tvalid;
  logic         enc_tready;
  logic [7:0]   tx_tdata;
  logic         tx_tvalid;
  logic         tx_tready;
  logic         tx_idle;

  modport master (
    output plain_tdata, plain_tvalid, enc_tdata, enc_tvalid, tx_tready, tx_idle,
    input  plain_tready, enc_tready, tx_tdata, tx_tvalid
  );

  modport slave (
    input  plain_tdata, plain_tvalid, enc_tdata, enc_tvalid, tx_tready, tx_idle,
    output plain_tready, enc_tready, tx_tdata, tx_tvalid
  );
endinterface

// File: rtl/aes_uart_tx_sched.sv
// Shares the UART byte transmitter between plaintext bursts and atomic 16-byte ciphertext
// blocks, and produces the TXE/TC/BUSY/ERE status bits.
module aes_uart_tx_sched #(
  parameter int unsigned PLAIN_BURST = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      aue_i,
  input  logic                      te_i,
  input  logic                      ee_i,
  input  logic                      tc_clr_i,
  aes_uart_tx_sched_if.slave        bus,
  output logic                      txe_o,
  output logic                      tc_o,
  output logic                      busy_o,
  output logic                      ere_o
);

  typedef enum logic [1:0] {StIdle, StCiph, StPlain} state_e;

  localparam logic [7:0] BurstMax = 8'(PLAIN_BURST);

  state_e       state_q, state_d;
  // Byte 0 of a block goes straight to tx_tdata, so only bytes 1..15 are kept here.
  logic [119:0] shift_q, shift_d;
  logic [3:0]   byte_cnt_q, byte_cnt_d;
  logic [7:0]   burst_cnt_q, burst_cnt_d;
  logic         last_ciph_q, last_ciph_d;
  logic [7:0]   tx_tdata_q, tx_tdata_d;
  logic         tx_tvalid_q, tx_tvalid_d;
  logic         tc_q, tc_d;

  logic req_c, req_p, grant_c, grant_p, tx_fire, plain_rdy, enc_rdy, tc_set;

  always_comb begin
    req_c       = aue_i & te_i & ee_i & bus.enc_tvalid;
    req_p       = aue_i & te_i & bus.plain_tvalid;
    tx_fire     = tx_tvalid_q & bus.tx_tready;
    state_d     = state_q;
    shift_d     = shift_q;
    byte_cnt_d  = byte_cnt_q;
    burst_cnt_d = burst_cnt_q;
    last_ciph_d = last_ciph_q;
    tx_tdata_d  = tx_tdata_q;
    tx_tvalid_d = tx_tvalid_q & ~tx_fire;
    grant_c     = 1'b0;
    grant_p     = 1'b0;
    enc_rdy     = 1'b0;
    plain_rdy   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!tx_tvalid_q) begin
          grant_c = req_c & (~req_p | ~last_ciph_q);
          grant_p = req_p & ~grant_c;
          enc_rdy = grant_c;
          if (grant_c) begin
            shift_d     = bus.enc_tdata[119:0];
            tx_tdata_d  = bus.enc_tdata[127:120];
            tx_tvalid_d = 1'b1;
            byte_cnt_d  = 4'd0;
            last_ciph_d = 1'b1;
            state_d     = StCiph;
          end else if (grant_p) begin
            burst_cnt_d = 8'd0;
            last_ciph_d = 1'b0;
            state_d     = StPlain;
          end
        end
      end
      StCiph: begin
        if (tx_fire) begin
          shift_d    = {shift_q[111:0], 8'h00};
          tx_tdata_d = shift_q[119:112];
          byte_cnt_d = byte_cnt_q + 4'd1;
          if (byte_cnt_q == 4'd15) begin
            state_d = StIdle;
          end else begin
            tx_tvalid_d = 1'b1;
          end
        end
      end
      StPlain: begin
        plain_rdy = (~tx_tvalid_q | bus.tx_tready) & aue_i & te_i;
        if (plain_rdy && bus.plain_tvalid) begin
          tx_tdata_d  = bus.plain_tdata;
          tx_tvalid_d = 1'b1;
          burst_cnt_d = burst_cnt_q + 8'd1;
          if (burst_cnt_d == BurstMax) state_d = StIdle;
        end else if (plain_rdy || !te_i) begin
          // Source ran dry, or transmit was disabled: any held byte drains from idle.
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (!aue_i) begin
      state_d     = StIdle;
      tx_tvalid_d = 1'b0;
      byte_cnt_d  = 4'd0;
      burst_cnt_d = 8'd0;
    end

    tc_set = (state_q == StIdle) & ~tx_tvalid_q & bus.tx_idle & ~req_c & ~req_p;
    tc_d   = tc_set | (tc_q & ~tc_clr_i & ~grant_c & ~grant_p);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      shift_q     <= '0;
      byte_cnt_q  <= '0;
      burst_cnt_q <= '0;
      last_ciph_q <= 1'b0;
      tx_tdata_q  <= '0;
      tx_tvalid_q <= 1'b0;
      tc_q        <= 1'b1;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      byte_cnt_q  <= byte_cnt_d;
      burst_cnt_q <= burst_cnt_d;
      last_ciph_q <= last_ciph_d;
      tx_tdata_q  <= tx_tdata_d;
      tx_tvalid_q <= tx_tvalid_d;
      tc_q        <= tc_d;
    end
  end

  assign bus.enc_tready   = enc_rdy;
  assign bus.plain_tready = plain_rdy;
  assign bus.tx_tdata     = tx_tdata_q;
  assign bus.tx_tvalid    = tx_tvalid_q;

  assign txe_o  = ~tx_tvalid_q;
  assign tc_o   = tc_q;
  assign busy_o = (state_q != StIdle) | tx_tvalid_q | ~bus.tx_idle;
  assign ere_o  = aue_i & te_i & ee_i & (state_q == StIdle) & ~tx_tvalid_q;

endmodule

// File: tb/tb_aes_uart_tx_sched.sv
// Scoreboard bench: tests queue the expected UART byte stream, a negedge monitor checks it.
module tb_aes_uart_tx_sched;
  localparam int unsigned Burst = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic aue, te, ee, tc_clr;
  logic txe, tc, busy, ere;

  aes_uart_tx_sched_if bus();

  aes_uart_tx_sched #(.PLAIN_BURST(Burst)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .aue_i   (aue),
    .te_i    (te),
    .ee_i    (ee),
    .tc_clr_i(tc_clr),
    .bus     (bus),
    .txe_o   (txe),
    .tc_o    (tc),
    .busy_o  (busy),
    .ere_o   (ere)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int enc_fires = 0;
  logic [7:0]   exp_q[$];
  logic [7:0]   plain_q[$];
  logic [127:0] enc_q[$];
  bit p_fire, e_fire, bp_en, rdy_set;
  bit stall_prev, aue_prev;
  logic [7:0] data_prev;

  localparam logic [127:0] B0 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] B1 = 128'hF0E1D2C3_B4A59687_78695A4B_3C2D1E0F;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_blk(input logic [127:0] b, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(b[127-8*i -: 8]);
  endtask

  task automatic push_plain(input logic [7:0] first, input int n, input bit expect_out);
    for (int i = 0; i < n; i++) begin
      plain_q.push_back(first + 8'(i));
      if (expect_out) exp_q.push_back(first + 8'(i));
    end
  endtask

  task automatic wait_drain(input string nm, input int limit);
    int n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      @(posedge clk);
      n++;
    end
    chk({nm, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_left(input int left, input int limit);
    int n = 0;
    while (exp_q.size() > left && n < limit) begin
      @(posedge clk);
      n++;
    end
    chk("wait_left", 32'(exp_q.size()), 32'(left));
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    aue = 1'b0; te = 1'b0; ee = 1'b0; tc_clr = 1'b0;
    rdy_set = 1'b1; bp_en = 1'b0;
    plain_q.delete(); enc_q.delete(); exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Monitor: scoreboard pop on every accepted byte, hold check while stalled.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
      p_fire = 1'b0;
      e_fire = 1'b0;
    end else begin
      if (stall_prev && aue_prev) begin
        chk("hold_valid", 32'(bus.tx_tvalid), 32'd1);
        chk("hold_data", 32'(bus.tx_tdata), 32'(data_prev));
      end
      if (bus.tx_tvalid && bus.tx_tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_byte: got %0h expected none", bus.tx_tdata);
        end else begin
          chk("tx_byte", 32'(bus.tx_tdata), 32'(exp_q.pop_front()));
        end
      end
      p_fire = bus.plain_tvalid & bus.plain_tready;
      e_fire = bus.enc_tvalid & bus.enc_tready;
      if (e_fire) enc_fires++;
      stall_prev = bus.tx_tvalid & ~bus.tx_tready;
      aue_prev   = aue;
      data_prev  = bus.tx_tdata;
    end
  end

  // Sources: FIFO / encryptor models plus the transmitter's ready.
  always @(posedge clk) begin
    #2;
    if (rst_n) begin
      if (p_fire && plain_q.size() != 0) void'(plain_q.pop_front());
      if (e_fire && enc_q.size() != 0) void'(enc_q.pop_front());
    end
    p_fire = 1'b0;
    e_fire = 1'b0;
    bus.plain_tvalid = (plain_q.size() != 0);
    bus.plain_tdata  = (plain_q.size() != 0) ? plain_q[0] : 8'h00;
    bus.enc_tvalid   = (enc_q.size() != 0);
    bus.enc_tdata    = (enc_q.size() != 0) ? enc_q[0] : 128'h0;
    bus.tx_tready    = bp_en ? 1'($urandom_range(0, 1)) : rdy_set;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    aue = 1'b0; te = 1'b0; ee = 1'b0; tc_clr = 1'b0;
    rdy_set = 1'b1; bp_en = 1'b0;
    bus.tx_idle = 1'b1;
    bus.tx_tready = 1'b1;
    bus.plain_tvalid = 1'b0; bus.plain_tdata = 8'h00;
    bus.enc_tvalid = 1'b0; bus.enc_tdata = 128'h0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_tvalid", 32'(bus.tx_tvalid), 32'd0);
    chk("rst_tdata", 32'(bus.tx_tdata), 32'd0);
    chk("rst_tc", 32'(tc), 32'd1);
    chk("rst_txe", 32'(txe), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ere", 32'(ere), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Cipher only: 16 back-to-back bytes
    @(posedge clk); #1;
    enc_q.push_back(B0);
    push_blk(B0, 16);
    aue = 1'b1; te = 1'b1; ee = 1'b1;
    @(negedge clk);
    chk("c_enc_tready", 32'(bus.enc_tready), 32'd1);
    chk("c_ere_idle", 32'(ere), 32'd1);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("c_tvalid_run", 32'(bus.tx_tvalid), 32'd1);
      if (i == 0) begin
        chk("c_tc_cleared", 32'(tc), 32'd0);
        chk("c_busy", 32'(busy), 32'd1);
      end
    end
    @(negedge clk);
    chk("c_tvalid_end", 32'(bus.tx_tvalid), 32'd0);
    chk("c_busy_end", 32'(busy), 32'd0);
    chk("c_tc_lag", 32'(tc), 32'd0);
    @(negedge clk);
    chk("c_tc_set", 32'(tc), 32'd1);
    chk("c_enc_fires", 32'(enc_fires), 32'd1);
    wait_drain("cipher", 20);

    // TC: set beats clear, clear alone, then set again
    @(posedge clk); #1 tc_clr = 1'b1;
    @(posedge clk); #1 tc_clr = 1'b0;
    @(negedge clk);
    chk("tc_set_wins", 32'(tc), 32'd1);
    @(posedge clk); #1 tc_clr = 1'b1; bus.tx_idle = 1'b0;
    @(posedge clk); #1 tc_clr = 1'b0;
    @(negedge clk);
    chk("tc_clr", 32'(tc), 32'd0);
    chk("tc_busy_line", 32'(busy), 32'd1);
    @(posedge clk); #1 bus.tx_idle = 1'b1;
    @(negedge clk);
    chk("tc_busy_off", 32'(busy), 32'd0);
    @(negedge clk);
    chk("tc_reset", 32'(tc), 32'd1);

    // Contention: cipher first after reset, then alternating block / burst
    do_reset();
    base = enc_fires;
    @(posedge clk); #1;
    enc_q.push_back(B0);
    enc_q.push_back(B1);
    plain_q.delete();
    push_blk(B0, 16);
    push_plain(8'h50, 4, 1'b1);
    push_blk(B1, 16);
    push_plain(8'h54, 4, 1'b1);
    aue = 1'b1; te = 1'b1; ee = 1'b1;
    wait_drain("contention", 300);
    repeat (3) @(negedge clk);
    chk("cont_enc_fires", 32'(enc_fires - base), 32'd2);
    chk("cont_plain_left", 32'(plain_q.size()), 32'd0);

    // Backpressure: random ready, cipher block then 4+2 plain bytes
    @(posedge clk); #1;
    enc_q.push_back(B1);
    push_blk(B1, 16);
    push_plain(8'h60, 6, 1'b1);
    bp_en = 1'b1;
    wait_drain("backpressure", 600);
    @(posedge clk); #1 bp_en = 1'b0; rdy_set = 1'b1;
    repeat (4) @(negedge clk);
    chk("bp_idle", 32'(bus.tx_tvalid), 32'd0);

    // Abort: aue drops after 5 cipher bytes
    base = enc_fires;
    @(posedge clk); #1;
    enc_q.push_back(B0);
    push_blk(B0, 5);
    wait_left(0, 100);
    #1 aue = 1'b0; rdy_set = 1'b0;
    @(negedge clk);
    chk("abort_pending", 32'(bus.tx_tdata), 32'h55);
    @(negedge clk);
    chk("abort_tvalid", 32'(bus.tx_tvalid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_ere", 32'(ere), 32'd0);
    @(posedge clk); #1;
    enc_q.push_back(B1);
    push_blk(B1, 16);
    aue = 1'b1; rdy_set = 1'b1;
    wait_drain("abort_restart", 60);
    chk("abort_enc_fires", 32'(enc_fires - base), 32'd2);

    // Graceful te drop after byte 3
    base = enc_fires;
    @(posedge clk); #1;
    enc_q.push_back(B0);
    enc_q.push_back(B1);
    push_blk(B0, 16);
    wait_left(12, 100);
    #1 te = 1'b0; bus.tx_idle = 1'b0;
    push_plain(8'h70, 3, 1'b0);
    wait_drain("te_drop", 60);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("te_no_pop", 32'(bus.plain_tready), 32'd0);
      chk("te_no_tx", 32'(bus.tx_tvalid), 32'd0);
      chk("te_busy", 32'(busy), 32'd1);
    end
    chk("te_enc_fires", 32'(enc_fires - base), 32'd1);
    chk("te_plain_left", 32'(plain_q.size()), 32'd3);
    @(posedge clk); #1 bus.tx_idle = 1'b1;
    @(negedge clk);
    chk("te_busy_off", 32'(busy), 32'd0);

    do_reset();
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
